// File: rtl/display_pkg.sv
// Shared constants and types for the memory-mapped seven-segment display scanner.
package display_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [31:0] PRINT_ADDR_A_DEF = 32'h8000_0064;
  localparam logic [31:0] PRINT_ADDR_B_DEF = 32'h0000_0000;
  localparam logic [31:0] CTRL_ADDR_DEF    = 32'h8000_0068;

  localparam int unsigned CTRL_ENABLE_BIT   = 0;
  localparam int unsigned CTRL_BLANK_LZ_BIT = 1;

  typedef struct packed {
    logic blank_lz;
    logic enable;
  } ctrl_t;

endpackage

// File: rtl/hex_to_7seg.sv
// Hex nibble to active-low seven-segment pattern, bit order {g,f,e,d,c,b,a}.
module hex_to_7seg
  import display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
    endcase
  end

endmodule

// File: rtl/mmio_display_scanner.sv
// Snoops CPU writes for a print value and control word, double-buffers the value and
// time-multiplexes it onto a shared seven-segment bus with per-digit anode enables.
module mmio_display_scanner
  import display_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 8,
  parameter int unsigned CLK_DIV      = 50000,
  parameter int unsigned DEAD_CYCLES  = 16,
  parameter logic [31:0] PRINT_ADDR_A = PRINT_ADDR_A_DEF,
  parameter logic [31:0] PRINT_ADDR_B = PRINT_ADDR_B_DEF,
  parameter logic [31:0] CTRL_ADDR    = CTRL_ADDR_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           MemoryAdr,
  input  logic [31:0]           MemoryData,
  input  logic                  wen,
  output logic [6:0]            seg_n,
  output logic [NUM_DIGITS-1:0] an_n,
  output logic [31:0]           shown_value,
  output logic                  frame_tick
);

  localparam int unsigned VW = NUM_DIGITS * 4;
  localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] DEAD_END = PW'(DEAD_CYCLES);
  localparam logic [DW-1:0] DIG_LAST = DW'(NUM_DIGITS - 1);

  logic [VW-1:0]         shadow_q;
  logic [VW-1:0]         display_q;
  logic [PW-1:0]         prescaler_q;
  logic [DW-1:0]         digit_q;
  ctrl_t                 ctrl_q;
  logic [6:0]            seg_q;
  logic [NUM_DIGITS-1:0] an_q;
  logic                  frame_tick_q;

  logic                  print_hit;
  logic                  ctrl_hit;
  logic                  slot_end;
  logic                  frame_end;
  logic                  dead;
  logic [3:0]            nibble;
  logic [6:0]            dec_seg;
  logic [NUM_DIGITS-1:0] lz_blank;
  logic                  upper_zero;
  logic [NUM_DIGITS-1:0] an_d;
  logic [6:0]            seg_d;

  assign print_hit = wen && ((MemoryAdr == PRINT_ADDR_A) || (MemoryAdr == PRINT_ADDR_B));
  assign ctrl_hit  = wen && (MemoryAdr == CTRL_ADDR);
  assign slot_end  = (prescaler_q == PRE_LAST);
  assign frame_end = slot_end && (digit_q == DIG_LAST);
  assign dead      = (prescaler_q < DEAD_END);

  always_comb begin
    nibble = 4'h0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (digit_q == DW'(d)) nibble = display_q[4*d +: 4];
    end
  end

  hex_to_7seg u_dec (
    .nibble (nibble),
    .seg    (dec_seg)
  );

  // A digit is a leading zero when it and every more-significant nibble are zero;
  // digit 0 is never blanked so a zero value still shows one "0".
  always_comb begin
    upper_zero = 1'b1;
    lz_blank   = '0;
    for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
      upper_zero  = upper_zero && (display_q[4*d +: 4] == 4'h0);
      lz_blank[d] = ctrl_q.blank_lz && upper_zero && (d != 0);
    end
  end

  always_comb begin
    an_d  = '1;
    seg_d = SEG_BLANK;
    if (ctrl_q.enable && !dead) begin
      for (int d = 0; d < NUM_DIGITS; d++) begin
        if ((digit_q == DW'(d)) && !lz_blank[d]) begin
          an_d[d] = 1'b0;
          seg_d   = dec_seg;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q     <= '0;
      display_q    <= '0;
      prescaler_q  <= '0;
      digit_q      <= '0;
      ctrl_q       <= '{blank_lz: 1'b0, enable: 1'b1};
      seg_q        <= SEG_BLANK;
      an_q         <= '1;
      frame_tick_q <= 1'b0;
    end else begin
      if (print_hit) shadow_q <= VW'(MemoryData);
      if (ctrl_hit) begin
        ctrl_q.enable   <= MemoryData[CTRL_ENABLE_BIT];
        ctrl_q.blank_lz <= MemoryData[CTRL_BLANK_LZ_BIT];
      end
      if (!ctrl_q.enable) begin
        // Idle: hold the scan at its origin but keep the buffer tracking the shadow.
        prescaler_q <= '0;
        digit_q     <= '0;
        display_q   <= shadow_q;
      end else begin
        prescaler_q <= slot_end ? '0 : prescaler_q + PW'(1);
        if (slot_end) digit_q <= (digit_q == DIG_LAST) ? '0 : digit_q + DW'(1);
        if (frame_end) display_q <= shadow_q;
      end
      seg_q        <= seg_d;
      an_q         <= an_d;
      frame_tick_q <= ctrl_q.enable && frame_end;
    end
  end

  assign seg_n       = seg_q;
  assign an_n        = an_q;
  assign frame_tick  = frame_tick_q;
  assign shown_value = 32'(display_q);

endmodule

// File: tb/tb_mmio_display_scanner.sv
// Directed plus randomized bench for mmio_display_scanner against a time-index reference model.
module tb_mmio_display_scanner;
  import display_pkg::*;

  localparam int unsigned ND    = 8;
  localparam int unsigned CD    = 4;
  localparam int unsigned DC    = 1;
  localparam int          FRAME = ND * CD;
  localparam logic [31:0] ADR_A = 32'h8000_0064;
  localparam logic [31:0] ADR_B = 32'h0000_0000;
  localparam logic [31:0] ADR_C = 32'h8000_0068;
  localparam logic [31:0] IDLE  = 32'h1000_0040;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   MemoryAdr = IDLE;
  logic [31:0]   MemoryData = '0;
  logic          wen = 1'b0;
  logic [6:0]    seg_n;
  logic [ND-1:0] an_n;
  logic [31:0]   shown_value;
  logic          frame_tick;

  always #5 clk = ~clk;

  mmio_display_scanner #(
    .NUM_DIGITS   (ND),
    .CLK_DIV      (CD),
    .DEAD_CYCLES  (DC),
    .PRINT_ADDR_A (ADR_A),
    .PRINT_ADDR_B (ADR_B),
    .CTRL_ADDR    (ADR_C)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .MemoryAdr   (MemoryAdr),
    .MemoryData  (MemoryData),
    .wen         (wen),
    .seg_n       (seg_n),
    .an_n        (an_n),
    .shown_value (shown_value),
    .frame_tick  (frame_tick)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: the scan position is one counter of cycles since the frame started.
  logic [31:0] m_shadow, m_disp;
  logic        m_en, m_lz;
  int          m_pos;
  logic [ND-1:0] e_an;
  logic [6:0]  e_seg;
  logic        e_tick, chk_seg, chk_tick;
  logic [6:0]  seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic model_step();
    int slot, phase;
    logic [3:0] nib;
    if (rst) begin
      e_an = '1; e_seg = SEG_BLANK; e_tick = 1'b0; chk_seg = 1'b1; chk_tick = 1'b1;
      m_shadow = '0; m_disp = '0; m_en = 1'b1; m_lz = 1'b0; m_pos = 0;
      return;
    end
    slot  = m_pos / CD;
    phase = m_pos % CD;
    nib   = 4'((m_disp >> (4 * slot)) & 32'hF);
    e_an = '1; e_seg = SEG_BLANK; chk_seg = 1'b1;
    e_tick   = m_en && (m_pos == FRAME - 1);
    chk_tick = m_en;
    if (m_en && phase >= DC) begin
      if (m_lz && slot != 0 && (m_disp >> (4 * slot)) == 0) chk_seg = 1'b0;
      else begin
        e_an[slot] = 1'b0;
        e_seg = seg_tab[nib];
      end
    end
    if (!m_en || e_tick) m_disp = m_shadow;
    m_pos = m_en ? (m_pos + 1) % FRAME : 0;
    if (wen) begin
      if (MemoryAdr == ADR_A || MemoryAdr == ADR_B) m_shadow = MemoryData;
      else if (MemoryAdr == ADR_C) begin
        m_en = MemoryData[0];
        m_lz = MemoryData[1];
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("an_n", 32'(an_n), 32'(e_an));
    if (chk_seg) check("seg_n", 32'(seg_n), 32'(e_seg));
    check("shown_value", shown_value, m_disp);
    if (chk_tick) check("frame_tick", 32'(frame_tick), 32'(e_tick));
  endtask

  task automatic write(input logic [31:0] a, input logic [31:0] d);
    MemoryAdr = a; MemoryData = d; wen = 1'b1;
    cycle();
    wen = 1'b0; MemoryAdr = IDLE; MemoryData = $urandom;
  endtask

  task automatic wait_pos(input int target);
    int n = 0;
    while (m_pos != target && n < 200) begin
      cycle();
      n++;
    end
    if (m_pos != target) begin
      $display("FAIL wait_pos: scan position %0d never reached", target);
      $fatal(1, "scan stalled");
    end
  endtask

  initial begin
    logic [31:0] a, d;
    int unsigned r;
    repeat (2) cycle();
    rst = 1'b0;
    check("reset shown_value", shown_value, 32'h0);

    // Idle scan of zero.
    repeat (40) cycle();

    // Print mid-frame: old value held until the frame boundary.
    wait_pos(10);
    write(ADR_A, 32'h1234_ABCD);
    check("held before boundary", shown_value, 32'h0);
    wait_pos(1);
    check("reloaded after boundary", shown_value, 32'h1234_ABCD);
    repeat (40) cycle();

    // Leading-zero blanking on a small value.
    write(ADR_C, 32'h3);
    write(ADR_A, 32'h5);
    repeat (70) cycle();

    // Print on the exact boundary cycle lands one frame late.
    write(ADR_C, 32'h1);
    wait_pos(FRAME - 1);
    write(ADR_B, 32'hFFFF_FFFF);
    check("boundary write deferred", shown_value, 32'h5);
    repeat (70) cycle();

    // Disable then re-enable.
    write(ADR_C, 32'h0);
    repeat (10) cycle();
    write(ADR_C, 32'h1);
    repeat (40) cycle();

    // Reset during digit 5.
    wait_pos(5 * CD + 2);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("rst an_n", 32'(an_n), 32'hFF);
    check("rst shown_value", shown_value, 32'h0);
    repeat (40) cycle();

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      d = $urandom >> $urandom_range(0, 31);
      if (r < 8) write(ADR_A, d);
      else if (r < 11) write(ADR_B, d);
      else if (r < 14) write(ADR_C, {$urandom_range(0, 7), 1'b1, ($urandom_range(0, 3) != 0)});
      else if (r < 20) begin
        a = $urandom;
        if (a == ADR_A || a == ADR_B || a == ADR_C) a = IDLE;
        write(a, d);
      end else if (r == 99) begin
        rst = 1'b1;
        cycle();
        rst = 1'b0;
      end else cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
